// File: rtl/data_memory.sv
// Word-addressed 32-bit memory with a fixed request-to-ack latency (LATENCY edges).
// Latency: ack rises LATENCY rising edges after the edge that accepts req.
// Backpressure: req is ignored while busy; a new request may be accepted in DONE.
// Optional MEM_STATS_EN: enables saturating completed-read/write counters.
module data_memory #(
  parameter int ADDR_W  = 11,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q;
  logic                we_q;
  logic                oor_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic                accept;
  logic                finish;
  logic                addr_oor;

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];

  // Any byte-address bit above the word index makes the request out of range.
  assign addr_oor = |(addr >> (ADDR_W + 2));

  // Next-state logic: accept from IDLE/DONE, count down in WAIT, complete into DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latency counter registers; reset wins over a simultaneous req.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request at acceptance so later input changes have no effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      idx_q   <= addr[ADDR_W+1:2];
      we_q    <= we;
      oor_q   <= addr_oor;
      wdata_q <= wdata;
    end
  end

  // Array write at DONE entry; contents survive reset, and reset aborts the write.
  always_ff @(posedge clk) begin
    if (!reset && finish && we_q && !oor_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  // Read data and error flag update at DONE entry; rdata holds across writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (finish) begin
      err_q <= oor_q;
      if (!we_q) begin
        rdata_q <= oor_q ? 32'd0 : mem_q[idx_q];
      end
    end
  end

  assign rdata = rdata_q;
  assign ack   = (state_q == DONE);
  assign busy  = (state_q == WAIT);
  assign err   = (state_q == DONE) & err_q;

`ifdef MEM_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  // Count completed in-range operations, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else if (finish && !oor_q) begin
      if (we_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: LATENCY=4 instance for the main table and
// corner sequences, LATENCY=1 instance for back-to-back and statistics.
module tb_data_memory;

`ifdef MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY = 4 instance
  logic        reset, req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ack, busy, err;
  logic [15:0] rd_count, wr_count;

  // LATENCY = 1 instance
  logic        reset1, req1, we1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ack1, busy1, err1;
  logic [15:0] rd_count1, wr_count1;

  data_memory #(.ADDR_W(11), .LATENCY(4)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  data_memory #(.ADDR_W(11), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset1), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1),
    .rd_count(rd_count1), .wr_count(wr_count1)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request on the LATENCY=4 instance, checking timing, rdata and err.
  task automatic do_txn(input string name, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_e);
    logic timing_ok;
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    // Scramble inputs after acceptance; the captured request must be used.
    req = 1'b0; we = ~w; addr = 32'hFFFF_FFFC; wdata = 32'h0BAD_0BAD;
    timing_ok = busy & ~ack;
    for (int i = 1; i < 4; i++) begin
      tick();
      timing_ok = timing_ok & busy & ~ack;
    end
    chk({name, "_wait"}, {31'd0, timing_ok}, 32'd1);
    tick();
    chk({name, "_ack"},   {30'd0, ack, busy}, {30'd0, 1'b1, 1'b0});
    chk({name, "_err"},   {31'd0, err}, {31'd0, exp_e});
    chk({name, "_rdata"}, rdata, exp_rd);
    tick();
    chk({name, "_idle"},  {30'd0, ack, busy}, 32'd0);
  endtask

  // One request on the LATENCY=1 instance; returns to IDLE afterwards.
  task automatic txn1(input string name, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd);
    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    tick();
    req1 = 1'b0;
    tick();
    chk({name, "_ack"},   {31'd0, ack1}, 32'd1);
    chk({name, "_rdata"}, rdata1, exp_rd);
    tick();
  endtask

  initial begin
    int acks;
    logic [31:0] ack_data;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0040, 32'h1111_2222, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_2000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0000, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_2000, 32'h9999_9999, 32'hA5A5_0000, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0042, 32'h0,         32'h1111_2222, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_1FFC, 32'hCAFE_F00D, 32'h1111_2222, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_1FFF, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[11] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b1};

    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    reset1 = 1'b1; req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
    tick();
    tick();
    reset = 1'b0; reset1 = 1'b0;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {29'd0, ack, busy, err}, 32'd0);
    chk("rst_counts", {rd_count, wr_count}, 32'd0);

    // Main table: write/read, sub-word address bits, range boundary.
    for (int i = 0; i < 12; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // req pulsed during WAIT with a different address is ignored.
    req = 1'b1; we = 1'b0; addr = 32'h0000_0010;
    tick();
    addr = 32'h0000_0000;
    acks = 0;
    ack_data = 32'd0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) req = 1'b0;
      tick();
      if (ack) begin
        acks++;
        ack_data = rdata;
      end
    end
    chk("wait_req_acks", acks, 32'd1);
    chk("wait_req_data", ack_data, 32'hDEAD_BEEF);

    // Reset two edges after accepting a write aborts it.
    req = 1'b1; we = 1'b1; addr = 32'h0000_0040; wdata = 32'h1234_5678;
    tick();
    req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_flags", {29'd0, ack, busy, err}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack) acks++;
    end
    chk("abort_no_ack", acks, 32'd0);
    do_txn("abort_read", 1'b0, 32'h0000_0040, 32'd0, 32'h1111_2222, 1'b0);

    // Reset has priority over a simultaneous req.
    reset = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0000_0010;
    tick();
    reset = 1'b0; req = 1'b0;
    tick();
    chk("rst_prio", {30'd0, ack, busy}, 32'd0);

    // LATENCY=1: prime three words, then back-to-back reads with req held.
    for (int k = 0; k < 3; k++) begin
      txn1($sformatf("l1_wr%0d", k), 1'b1, 32'(k * 4), 32'h1000_0000 + 32'(k), 32'd0);
    end
    we1 = 1'b0;
    req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr1 = 32'(k * 4);
      tick();
      chk($sformatf("b2b_acc%0d", k), {30'd0, ack1, busy1}, 32'd1);
      if (k == 2) req1 = 1'b0;
      tick();
      chk($sformatf("b2b_ack%0d", k), {30'd0, ack1, busy1}, 32'd2);
      chk($sformatf("b2b_rd%0d", k), rdata1, 32'h1000_0000 + 32'(k));
    end
    tick();
    chk("b2b_idle", {30'd0, ack1, busy1}, 32'd0);
    chk("b2b_counts", {rd_count1, wr_count1}, STATS ? {16'd3, 16'd3} : 32'd0);

    // Statistics: 2 writes, 3 in-range reads, 1 out-of-range read.
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    chk("st_rst_counts", {rd_count1, wr_count1}, 32'd0);
    txn1("st_w0", 1'b1, 32'h0000_000C, 32'h0000_00CC, 32'd0);
    txn1("st_w1", 1'b1, 32'h0000_0010, 32'h0000_0110, 32'd0);
    txn1("st_r0", 1'b0, 32'h0000_0000, 32'd0, 32'h1000_0000);
    txn1("st_r1", 1'b0, 32'h0000_000C, 32'd0, 32'h0000_00CC);
    txn1("st_r2", 1'b0, 32'h0000_0010, 32'd0, 32'h0000_0110);
    txn1("st_oor", 1'b0, 32'h0000_2000, 32'd0, 32'd0);
    chk("st_rd_count", {16'd0, rd_count1}, STATS ? 32'd3 : 32'd0);
    chk("st_wr_count", {16'd0, wr_count1}, STATS ? 32'd2 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning the number of word-index bits, giving a depth of 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 4, meaning the number of clk rising edges from request acceptance to completion; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 1 bit: request strobe, sampled at rising edges.
REQ-006 SHALL have port we, input, 1 bit: 1 = write, 0 = read; qualified by req.
REQ-007 SHALL have port addr, input, 32 bits: byte address; word index = addr[ADDR_W+1:2]; addr[1:0] ignored.
REQ-008 SHALL have port wdata, input, 32 bits: write word; byte 3 = [31:24], byte 0 = [7:0].
REQ-009 SHALL have port rdata, output, 32 bits: read word, same byte order as wdata.
REQ-010 SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port busy, output, 1 bit: high while a request is in flight.
REQ-012 SHALL have port err, output, 1 bit: valid with ack; high when the completed request was out of range.
REQ-013 SHALL have ports rd_count and wr_count, outputs, 16 bits each: completed-operation statistics (see Configuration).

Function
REQ-014 SHALL implement states IDLE, WAIT and DONE; busy = 1 only in WAIT; ack = 1 only in DONE.
REQ-015 SHALL accept req at a rising edge when in IDLE or DONE, latching addr, we and wdata, then entering WAIT with an internal counter set to LATENCY-1.
REQ-016 SHALL, in WAIT, decrement the counter at each edge and enter DONE at the edge where the counter equals 0, so that ack rises exactly LATENCY edges after the accepting edge.
REQ-017 SHALL commit a write to the array at the DONE-entry edge, using the latched values.
REQ-018 SHALL load rdata from the array at the DONE-entry edge for a read, and hold rdata until the next read completes; writes leave rdata unchanged.
REQ-019 SHALL treat a request as out of range when addr[31:ADDR_W+2] is nonzero; such a request completes with the normal latency, err = 1, no array write, and rdata = 0 if it is a read.
REQ-020 SHALL ignore req asserted while busy = 1; the request is not queued.
REQ-021 SHALL, when req = 1 in DONE, accept the new request (back-to-back); otherwise DONE returns to IDLE after one cycle.
REQ-022 SHALL let a read accepted after a completed write to the same word return the written data.
REQ-023 SHALL ignore changes on addr, we and wdata after acceptance.

Reset
REQ-024 SHALL, on reset = 1 at a rising edge, enter IDLE with rdata = 0, ack = 0, busy = 0, err = 0, rd_count = 0 and wr_count = 0.
REQ-025 SHALL, when reset occurs mid-operation, abort the in-flight request with no array write and no ack.
REQ-026 SHALL give reset priority over a simultaneous req.
REQ-027 SHALL NOT clear array contents on reset.

Configuration
REQ-028 SHALL provide macro MEM_STATS_EN.
REQ-029 SHALL, when MEM_STATS_EN is defined, increment rd_count for each in-range read and wr_count for each in-range write at the DONE-entry edge, saturating at 16'hFFFF.
REQ-030 SHALL, when MEM_STATS_EN is not defined, compile out the counter logic, keep both ports, and tie rd_count and wr_count to 0.

Verification
REQ-031 SHALL cover this scenario: write addr = 0x0000_0010, wdata = 0xDEAD_BEEF, then read addr = 0x0000_0013 -> read ack exactly 4 edges after acceptance, rdata = 0xDEAD_BEEF, err = 0.
REQ-032 SHALL cover this scenario: read addr = 0x0000_2000 (ADDR_W = 11) -> ack with err = 1, rdata = 0; a later read of word 0 shows no corruption.
REQ-033 SHALL cover this scenario: req pulsed during WAIT with a different addr -> ignored; exactly one ack occurs, carrying the first request's data.
REQ-034 SHALL cover this scenario: reset asserted 2 edges after accepting a write of 0x1234_5678 to 0x40 -> no ack; a later read of 0x40 returns the prior contents.
REQ-035 SHALL cover this scenario: back-to-back req held high for 3 reads with LATENCY = 1 -> ack every second cycle, with rdata matching each address in order.
REQ-036 SHALL cover this scenario: with MEM_STATS_EN defined, 3 in-range reads, 2 writes and 1 out-of-range read -> rd_count = 3, wr_count = 2; with MEM_STATS_EN undefined, both counts read 0.
